// File: rtl/fetch_block_pkg.sv
// Shared fetch-stage definitions: word and instruction types, pipeline
// control signal types, fetch FSM states and instruction-memory alignment.
package GENERAL_DEFS;

    typedef logic [31:0] WORD;
    typedef logic [31:0] instruction;
    typedef logic        stall_pipeline_sig;
    typedef logic        flush_pipeline_sig;

    // FETCH issues requests, WAIT holds one live outstanding request,
    // DROP holds one outstanding request whose response must be discarded.
    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        DROP  = 2'd2
    } fetch_state_t;

    // Instruction memory addresses are halfword aligned.
    localparam WORD IMEM_ADDR_ALIGN = 32'd2;
    localparam WORD PC_STEP         = 32'd2;

    // One instruction-queue entry: the fetched word and its address.
    typedef struct packed {
        WORD        pc;
        instruction instr;
    } fetch_entry_t;

    // Clear the sub-alignment address bits.
    function automatic WORD align_addr(input WORD addr);
        return addr & ~(IMEM_ADDR_ALIGN - 32'd1);
    endfunction

endpackage

// File: rtl/fetch_block_queue.sv
// fetch_queue: small shift-register instruction queue. Entry 0 is the head
// and is a register, so everything read from the head is registered.
// Push and pop in one cycle keep the count; flush empties the queue.
module fetch_queue
    import GENERAL_DEFS::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                         clk_i,
    input  logic                         reset_i,
    input  logic                         push_i,
    input  logic                         pop_i,
    input  logic                         flush_i,
    input  fetch_entry_t                 data_i,
    output fetch_entry_t                 head_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o,
    output logic                         head_valid_o
);

    localparam int CW = $clog2(DEPTH + 1);

    fetch_entry_t  r_mem [DEPTH];
    logic [CW-1:0] r_count;
    logic          r_valid;

    logic          w_pop;
    logic          w_push;
    logic [CW-1:0] w_wr_idx;
    logic [CW-1:0] w_count_nxt;

    assign w_pop       = pop_i && (r_count != '0);
    assign w_push      = push_i && ((r_count != CW'(DEPTH)) || w_pop);
    assign w_wr_idx    = r_count - CW'(w_pop);
    assign w_count_nxt = r_count + CW'(w_push) - CW'(w_pop);

    // Shift out the head on pop, write the new entry behind the survivors.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_count <= '0;
            r_valid <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (flush_i) begin
            r_count <= '0;
            r_valid <= 1'b0;
        end else begin
            if (w_pop) begin
                for (int i = 0; i < DEPTH - 1; i++) begin
                    r_mem[i] <= r_mem[i+1];
                end
            end
            for (int i = 0; i < DEPTH; i++) begin
                if (w_push && (w_wr_idx == CW'(i))) begin
                    r_mem[i] <= data_i;
                end
            end
            r_count <= w_count_nxt;
            r_valid <= (w_count_nxt != '0);
        end
    end

    assign head_o       = r_mem[0];
    assign count_o      = r_count;
    assign head_valid_o = r_valid;

endmodule

// File: rtl/fetch_block.sv
// fetch_block: instruction fetch stage. Issues halfword-aligned requests to
// instruction memory with at most one outstanding, queues responses in a
// two-entry fetch_queue and presents the head to decode from registers.
// Optional feature macro: FETCH_PERF_CNT_EN adds stall_cycles_o, a
// saturating count of cycles where decode stalls on a valid instruction.
// Only QUEUE_DEPTH = 2 is supported.
module fetch_block
    import GENERAL_DEFS::*;
#(
    parameter WORD RESET_PC    = 32'h0000_0000,
    parameter int  QUEUE_DEPTH = 2
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  stall_pipeline_sig stall_pipeline_i,
    input  flush_pipeline_sig flush_pipeline_i,
    input  WORD               branch_target_i,
    output logic              imem_req_o,
    output WORD               imem_addr_o,
    input  logic              imem_ready_i,
    input  logic              imem_rvalid_i,
    input  instruction        imem_rdata_i,
    output instruction        instruction_o,
    output WORD               program_counter_o,
    output logic              is_valid_o
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]       stall_cycles_o
`endif
);

    localparam int CW = $clog2(QUEUE_DEPTH + 1);

    fetch_state_t  r_state;
    WORD           r_pc;
    WORD           r_req_pc;
    logic          r_active;

    logic [CW-1:0] w_count;
    logic          w_outstanding;
    logic          w_has_room;
    logic          w_accept;
    logic          w_push;
    logic          w_pop;
    logic          w_head_valid;
    fetch_entry_t  w_push_data;
    fetch_entry_t  w_head;

    // r_active keeps the request line low for the first cycle after reset.
    assign w_outstanding = (r_state != FETCH);
    assign w_has_room    = (int'(w_count) + int'(w_outstanding)) < QUEUE_DEPTH;
    assign imem_req_o    = r_active && (r_state == FETCH) && w_has_room;
    assign imem_addr_o   = r_pc;
    assign w_accept      = imem_req_o && imem_ready_i;

    // Only a live response is queued; a flush in the same cycle discards it.
    assign w_push        = (r_state == WAIT) && imem_rvalid_i && !flush_pipeline_i;
    assign w_pop         = w_head_valid && !stall_pipeline_i;
    assign w_push_data   = '{pc: r_req_pc, instr: imem_rdata_i};

    // Fetch FSM and fetch PC; a flush redirects the PC and decides whether
    // an in-flight response still has to be swallowed.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state  <= FETCH;
            r_pc     <= align_addr(RESET_PC);
            r_active <= 1'b0;
        end else begin
            r_active <= 1'b1;
            if (flush_pipeline_i) begin
                r_pc <= align_addr(branch_target_i);
                case (r_state)
                    FETCH:   r_state <= w_accept ? DROP : FETCH;
                    WAIT,
                    DROP:    r_state <= imem_rvalid_i ? FETCH : DROP;
                    default: r_state <= FETCH;
                endcase
            end else begin
                case (r_state)
                    FETCH: begin
                        if (w_accept) begin
                            r_state <= WAIT;
                            r_pc    <= r_pc + PC_STEP;
                        end
                    end
                    WAIT: begin
                        if (imem_rvalid_i) r_state <= FETCH;
                    end
                    DROP: begin
                        if (imem_rvalid_i) r_state <= FETCH;
                    end
                    default: r_state <= FETCH;
                endcase
            end
        end
    end

    // Remember the address of the accepted request for its response.
    always_ff @(posedge clk_i) begin
        if (w_accept) r_req_pc <= r_pc;
    end

    fetch_queue #(
        .DEPTH(QUEUE_DEPTH)
    ) u_queue (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
        .push_i       (w_push),
        .pop_i        (w_pop),
        .flush_i      (flush_pipeline_i),
        .data_i       (w_push_data),
        .head_o       (w_head),
        .count_o      (w_count),
        .head_valid_o (w_head_valid)
    );

    assign instruction_o     = w_head.instr;
    assign program_counter_o = w_head.pc;
    assign is_valid_o        = w_head_valid;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] r_stall_cycles;

    // Count decode-stall cycles on a valid instruction, saturating at all-ones.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_stall_cycles <= '0;
        end else if (is_valid_o && stall_pipeline_i && (r_stall_cycles != '1)) begin
            r_stall_cycles <= r_stall_cycles + 32'd1;
        end
    end

    assign stall_cycles_o = r_stall_cycles;
`endif

endmodule

// File: tb/tb_fetch_block.sv
`timescale 1ns/1ps
module tb_fetch_block;

    localparam logic [31:0] RST_PC = 32'h0000_0100;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, stall, flush, ready, rvalid;
    logic [31:0] tgt, rdata;
    logic        req, valid;
    logic [31:0] addr, instr_o, pc_o;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] stall_cnt;
`endif

    fetch_block #(.RESET_PC(RST_PC), .QUEUE_DEPTH(2)) dut (
        .clk_i             (clk),
        .reset_i           (reset),
        .stall_pipeline_i  (stall),
        .flush_pipeline_i  (flush),
        .branch_target_i   (tgt),
        .imem_req_o        (req),
        .imem_addr_o       (addr),
        .imem_ready_i      (ready),
        .imem_rvalid_i     (rvalid),
        .imem_rdata_i      (rdata),
        .instruction_o     (instr_o),
        .program_counter_o (pc_o),
        .is_valid_o        (valid)
`ifdef FETCH_PERF_CNT_EN
        ,
        .stall_cycles_o    (stall_cnt)
`endif
    );

    int vectors = 0;
    int miscompares = 0;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ins;
    } ent_t;

    // memory contents: upper half is the inverted address, lower half the address
    function automatic logic [31:0] memval(input logic [31:0] a);
        return {~a[15:0], a[15:0]};
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic timeout_fail(input string nm);
        vectors++;
        miscompares++;
        $display("FAIL %s: event did not occur within cycle budget", nm);
    endtask

    // memory model state
    bit          mem_pend = 0;
    logic [31:0] mem_addr = '0;
    int          mem_cnt = 0;
    int          mem_lat = 1;

    // reference model state
    ent_t        mq[$];
    bit          m_outst = 0, m_drop = 0, m_run = 0, m_last_reset = 0, m_req_exp = 0;
    logic [31:0] m_pc = '0, m_out_addr = '0;

    // logs of accepted request addresses and delivered instruction addresses
    logic [31:0] acc_log[$];
    logic [31:0] deliv_log[$];

    // snapshot of one cycle's inputs and DUT outputs
    logic        s_reset, s_stall, s_flush, s_ready, s_rvalid, s_req, s_valid;
    logic [31:0] s_tgt, s_addr, s_pc;

    task automatic model_step();
        bit acc, pend_after;
        if (s_reset) begin
            mq.delete();
            m_outst = 0; m_drop = 0; m_run = 0; m_last_reset = 1;
            m_pc = RST_PC;
        end else begin
            m_last_reset = 0;
            acc = m_req_exp && s_ready;
            if (s_flush) begin
                pend_after = (m_outst && !s_rvalid) || acc;
                if (acc) m_out_addr = m_pc;
                mq.delete();
                m_outst = pend_after;
                m_drop  = pend_after;
                m_pc    = s_tgt & ~32'd1;
            end else begin
                if (mq.size() > 0 && !s_stall) void'(mq.pop_front());
                if (s_rvalid && m_outst) begin
                    if (!m_drop) mq.push_back(ent_t'{m_out_addr, memval(m_out_addr)});
                    m_outst = 0; m_drop = 0;
                end
                if (acc) begin
                    m_outst = 1; m_drop = 0;
                    m_out_addr = m_pc;
                    m_pc = m_pc + 32'd2;
                end
            end
            m_run = 1;
        end
    endtask

    task automatic compare();
        m_req_exp = m_run && !m_outst && (mq.size() < 2);
        check("imem_req", 32'(req), 32'(m_req_exp));
        if (m_req_exp && req === 1'b1) check("imem_addr", addr, m_pc);
        check("is_valid", 32'(valid), 32'(mq.size() > 0));
        if (mq.size() > 0) begin
            check("program_counter", pc_o, mq[0].pc);
            check("instruction", instr_o, mq[0].ins);
        end
        if (m_last_reset) begin
            check("reset_instr", instr_o, 32'h0);
            check("reset_pc", pc_o, 32'h0);
        end
    endtask

    // one clock cycle: memory drives, edge, logs, memory update, model, compare
    task automatic cycle();
        rvalid = mem_pend && (mem_cnt == 0);
        rdata  = rvalid ? memval(mem_addr) : 32'hDEAD_BEEF;
        s_reset = reset; s_stall = stall; s_flush = flush; s_ready = ready;
        s_rvalid = rvalid; s_tgt = tgt; s_req = req; s_addr = addr;
        s_valid = valid; s_pc = pc_o;
        @(posedge clk);
        @(negedge clk);
        if (s_req === 1'b1 && s_ready && !s_reset) acc_log.push_back(s_addr);
        if (s_valid === 1'b1 && !s_stall && !s_flush && !s_reset) deliv_log.push_back(s_pc);
        if (s_rvalid) mem_pend = 0;
        else if (mem_pend && mem_cnt > 0) mem_cnt--;
        if (s_req === 1'b1 && s_ready && !s_reset) begin
            mem_pend = 1; mem_addr = s_addr; mem_cnt = mem_lat - 1;
        end
        model_step();
        compare();
    endtask

    task automatic wait_req(input int maxc, input string nm);
        int n = 0;
        while (req !== 1'b1 && n < maxc) begin cycle(); n++; end
        if (req !== 1'b1) timeout_fail(nm);
    endtask

    task automatic wait_valid(input int maxc, input string nm);
        int n = 0;
        while (valid !== 1'b1 && n < maxc) begin cycle(); n++; end
        if (valid !== 1'b1) timeout_fail(nm);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, a, b;
        logic [31:0] held_pc, held_ins;
        reset = 1; stall = 0; flush = 0; ready = 1; tgt = '0; rvalid = 0; rdata = '0;
        @(negedge clk);

        // reset and first fetch latency
        repeat (3) cycle();
        check("reset_valid", 32'(valid), 32'h0);
        check("reset_req", 32'(req), 32'h0);
        reset = 0;
        n = 0;
        do begin cycle(); n++; end while (valid !== 1'b1 && n < 10);
        check("first_valid_latency", 32'(n), 32'd3);
        check("first_pc", pc_o, 32'h0000_0100);
        check("first_instr", instr_o, 32'hFEFF_0100);
        for (int i = 0; i < 8; i++) begin
            ready = (i % 3) != 1;
            cycle();
        end
        ready = 1;
        if (acc_log.size() < 3) timeout_fail("first_requests");
        else begin
            check("req0_addr", acc_log[0], 32'h0000_0100);
            check("req1_addr", acc_log[1], 32'h0000_0102);
            check("req2_addr", acc_log[2], 32'h0000_0104);
        end

        // stall for 5 cycles while valid
        wait_valid(10, "stall_start");
        stall = 1;
        held_pc = pc_o; held_ins = instr_o;
        repeat (5) begin
            cycle();
            check("stall_hold_pc", pc_o, held_pc);
            check("stall_hold_instr", instr_o, held_ins);
        end
        check("no_req_when_full", 32'(req), 32'h0);
        stall = 0;
        repeat (12) cycle();
        for (int i = 0; i < deliv_log.size(); i++)
            check("in_order_delivery", deliv_log[i], RST_PC + 32'(2 * i));

        // flush with a request outstanding
        mem_lat = 3;
        wait_req(10, "flush_req");
        cycle();
        a = acc_log.size();
        flush = 1; tgt = 32'h0000_0201;
        cycle();
        flush = 0;
        check("flush_valid_low", 32'(valid), 32'h0);
        wait_valid(20, "flush_refill");
        check("flush_pc", pc_o, 32'h0000_0200);
        check("flush_instr", instr_o, 32'hFDFF_0200);
        if (acc_log.size() > a) check("flush_req_addr", acc_log[a], 32'h0000_0200);
        else timeout_fail("flush_req_addr");

        // flush together with rvalid and stall
        mem_lat = 1;
        stall = 1;
        wait_req(10, "coincide_req");
        cycle();
        flush = 1; tgt = 32'h0000_03A0;
        cycle();
        flush = 0; stall = 0;
        b = acc_log.size();
        check("coincide_valid_low", 32'(valid), 32'h0);
        wait_valid(10, "coincide_refill");
        check("coincide_pc", pc_o, 32'h0000_03A0);
        check("coincide_instr", instr_o, 32'hFC5F_03A0);
        if (acc_log.size() > b) check("coincide_req_addr", acc_log[b], 32'h0000_03A0);
        else timeout_fail("coincide_req_addr");

        // fetch PC wrap
        flush = 1; tgt = 32'hFFFF_FFFE;
        cycle();
        flush = 0;
        b = acc_log.size();
        repeat (10) cycle();
        if (acc_log.size() > b + 1) begin
            check("wrap_addr0", acc_log[b], 32'hFFFF_FFFE);
            check("wrap_addr1", acc_log[b+1], 32'h0000_0000);
        end else timeout_fail("wrap_requests");

        // reset with a request outstanding
        mem_lat = 3;
        wait_req(10, "midreset_req");
        cycle();
        reset = 1;
        cycle();
        reset = 0;
        wait_valid(15, "midreset_refill");
        check("midreset_pc", pc_o, 32'h0000_0100);
        check("midreset_instr", instr_o, 32'hFEFF_0100);

`ifdef FETCH_PERF_CNT_EN
        mem_lat = 1;
        reset = 1;
        repeat (2) cycle();
        check("perf_reset", stall_cnt, 32'h0);
        reset = 0;
        wait_valid(10, "perf_valid");
        stall = 1;
        repeat (7) cycle();
        stall = 0;
        cycle();
        check("perf_count", stall_cnt, 32'd7);
        reset = 1;
        cycle();
        check("perf_cleared", stall_cnt, 32'h0);
        reset = 0;
        repeat (3) cycle();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
